// File: rtl/buzzer_round_ctrl.sv
// Round controller for a two-player quiz buzzer: arms buzzers, grants the answer turn,
// times the answer window, scores the judgement and detects the winner.
// Optional feature macro: BUZZER_PENALTY_EN (wrong answer / expiry costs one point).
module buzzer_round_ctrl #(
    parameter int ANSWER_CYCLES = 16,
    parameter int WIN_SCORE     = 3,
    parameter int SCORE_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         keypad_in,
    input  logic               start,
    input  logic               judge_ok,
    input  logic               judge_ng,
    output logic [2:0]         state,
    output logic               turn1,
    output logic               turn2,
    output logic               lock1,
    output logic               lock2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               timeout,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam logic [3:0]         KEY_P1    = 4'b1001;
    localparam logic [3:0]         KEY_P2    = 4'b0111;
    localparam int                 TIMER_W   = $clog2(ANSWER_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(ANSWER_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_ANSWER = 3'd2,
        S_DONE   = 3'd3
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         prev_key_q, prev_key_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               turn1_q, turn1_d, turn2_q, turn2_d;
    logic               lock1_q, lock1_d, lock2_q, lock2_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic               timeout_q, timeout_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;

    logic               press1, press2, expired;
    logic [SCORE_W-1:0] turn_score_inc;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // A held key is one press: only the transition onto a player code counts.
    assign press1         = (keypad_in == KEY_P1) && (prev_key_q != KEY_P1);
    assign press2         = (keypad_in == KEY_P2) && (prev_key_q != KEY_P2);
    assign expired        = (timer_q == TIMER_END);
    assign turn_score_inc = turn1_q ? sat_inc(score1_q) : sat_inc(score2_q);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        prev_key_d  = keypad_in;
        timer_d     = timer_q;
        turn1_d     = turn1_q;
        turn2_d     = turn2_q;
        lock1_d     = lock1_q;
        lock2_d     = lock2_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        timeout_d   = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_ARMED;
                    score1_d    = '0;
                    score2_d    = '0;
                    lock1_d     = 1'b0;
                    lock2_d     = 1'b0;
                    game_over_d = 1'b0;
                    winner_d    = 2'b00;
                end
            end
            S_ARMED: begin
                if (press1 && !lock1_q) begin
                    state_d = S_ANSWER;
                    turn1_d = 1'b1;
                    timer_d = '0;
                end else if (press2 && !lock2_q) begin
                    state_d = S_ANSWER;
                    turn2_d = 1'b1;
                    timer_d = '0;
                end
            end
            S_ANSWER: begin
                timer_d = timer_q + 1'b1;
                if (judge_ok) begin
                    if (turn1_q) score1_d = turn_score_inc;
                    else         score2_d = turn_score_inc;
                    lock1_d = 1'b0;
                    lock2_d = 1'b0;
                    turn1_d = 1'b0;
                    turn2_d = 1'b0;
                    if (turn_score_inc == SCORE_WIN) begin
                        state_d     = S_DONE;
                        game_over_d = 1'b1;
                        winner_d    = turn1_q ? 2'b01 : 2'b10;
                    end else begin
                        state_d = S_ARMED;
                    end
                end else if (judge_ng || expired) begin
                    timeout_d = !judge_ng;
                    state_d   = S_ARMED;
                    turn1_d   = 1'b0;
                    turn2_d   = 1'b0;
                    // Both players locked means nobody can answer: the question is dead.
                    if (turn1_q) begin
                        lock1_d = !lock2_q;
                        lock2_d = 1'b0;
                    end else begin
                        lock2_d = !lock1_q;
                        lock1_d = 1'b0;
                    end
`ifdef BUZZER_PENALTY_EN
                    if (turn1_q) score1_d = sat_dec(score1_q);
                    else         score2_d = sat_dec(score2_q);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prev_key_q  <= 4'b0000;
            timer_q     <= '0;
            turn1_q     <= 1'b0;
            turn2_q     <= 1'b0;
            lock1_q     <= 1'b0;
            lock2_q     <= 1'b0;
            score1_q    <= '0;
            score2_q    <= '0;
            timeout_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            prev_key_q  <= prev_key_d;
            timer_q     <= timer_d;
            turn1_q     <= turn1_d;
            turn2_q     <= turn2_d;
            lock1_q     <= lock1_d;
            lock2_q     <= lock2_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            timeout_q   <= timeout_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign state     = state_q;
    assign turn1     = turn1_q;
    assign turn2     = turn2_q;
    assign lock1     = lock1_q;
    assign lock2     = lock2_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign timeout   = timeout_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule
